// File: rtl/mux_arb_pkg.sv
// Shared constants and select/rotation helpers for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // One-hot grant to binary mux select; an all-zero grant maps to 0.
    function automatic logic [SEL_W-1:0] grant_to_sel(input logic [N_REQ-1:0] grant);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) sel = SEL_W'(i);
        end
        return sel;
    endfunction

    function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        return N_REQ'(1) << sel;
    endfunction

    // First set bit of req searching upward from last+1, wrapping back to last itself.
    // Callers only use the result when req is non-zero.
    function automatic logic [SEL_W-1:0] rr_next(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] last);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] cand;
        logic             found;
        idx   = last;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last + SEL_W'(i);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/data/grant bundle between four requesters and the shared mux arbiter.
interface mux4_rr_arbiter_if #(
    parameter int DW = 1
);
    import mux_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [DW-1:0]    d1;
    logic [DW-1:0]    d2;
    logic [DW-1:0]    d3;
    logic [DW-1:0]    d4;
    logic [N_REQ-1:0] grant;
    logic             I0;
    logic             I1;
    logic [DW-1:0]    Q;
    logic             q_valid;
    logic             busy;

    modport master (
        output req, d1, d2, d3, d4,
        input  grant, I0, I1, Q, q_valid, busy
    );

    modport slave (
        input  req, d1, d2, d3, d4,
        output grant, I0, I1, Q, q_valid, busy
    );

endinterface

// File: rtl/mux4_datapath.sv
// Combinational 4:1 select of d1..d4 by {I1,I0}; feeds the arbiter's Q register.
module mux4_datapath
    import mux_arb_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [DW-1:0]    d1,
    input  logic [DW-1:0]    d2,
    input  logic [DW-1:0]    d3,
    input  logic [DW-1:0]    d4,
    output logic [DW-1:0]    y
);

    always_comb begin
        unique case (sel)
            2'd0:    y = d1;
            2'd1:    y = d2;
            2'd2:    y = d3;
            default: y = d4;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux; registered grant, select decode and Q/q_valid.
// Define HOLD_LIMIT_EN to cap a holder at MAX_HOLD consecutive cycles while others wait.
module mux4_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    mux4_rr_arbiter_if.slave    bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be within 2..255");
    end

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [SEL_W-1:0] sel_hold_q;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] pick;
    logic             take;
    logic             busy;
    logic [DW-1:0]    mux_y;
    logic [DW-1:0]    q_q;
    logic             q_valid_q;

`ifdef HOLD_LIMIT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0]       hold_q, hold_d;
    logic [N_REQ-1:0] others;
    assign others = bus.req & ~sel_to_onehot(last_q);
`endif

    // last_q always names the current owner while in ST_GRANT.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        take    = 1'b0;
        pick    = last_q;
`ifdef HOLD_LIMIT_EN
        hold_d  = hold_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    take = 1'b1;
                    pick = rr_next(bus.req, last_q);
                end
            end
            ST_GRANT: begin
                if (bus.req[last_q]) begin
`ifdef HOLD_LIMIT_EN
                    if (hold_q == HOLD_LAST) begin
                        if (|others) begin
                            take = 1'b1;
                            pick = rr_next(others, last_q);
                        end else begin
                            hold_d = '0;
                        end
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
`endif
                end else if (|bus.req) begin
                    take = 1'b1;
                    pick = rr_next(bus.req, last_q);
                end else begin
                    state_d = ST_IDLE;
                    grant_d = '0;
`ifdef HOLD_LIMIT_EN
                    hold_d  = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (take) begin
            state_d = ST_GRANT;
            grant_d = sel_to_onehot(pick);
            last_d  = pick;
`ifdef HOLD_LIMIT_EN
            hold_d  = '0;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= SEL_W'(N_REQ - 1);
`ifdef HOLD_LIMIT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    // Select is decoded only from registers, so it moves at clock edges and holds while idle.
    assign busy = |grant_q;
    assign sel  = busy ? grant_to_sel(grant_q) : sel_hold_q;

    mux4_datapath #(.DW(DW)) u_datapath (
        .sel (sel),
        .d1  (bus.d1),
        .d2  (bus.d2),
        .d3  (bus.d3),
        .d4  (bus.d4),
        .y   (mux_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_hold_q <= '0;
            q_q        <= '0;
            q_valid_q  <= 1'b0;
        end else begin
            q_valid_q <= busy;
            if (busy) begin
                sel_hold_q <= sel;
                q_q        <= mux_y;
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.I0      = sel[0];
    assign bus.I1      = sel[1];
    assign bus.Q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, corner sequences, random vs. reference model.
module tb_mux4_rr_arbiter;

    localparam int DW       = 1;
    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;

    mux4_rr_arbiter_if #(.DW(DW)) bus ();

    mux4_rr_arbiter #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 idle), rotation pointer, hold count, last select, Q.
    int   m_owner;
    int   m_last;
    int   m_hold;
    int   m_sel;
    logic m_q;
    logic m_qv;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_sel   = 0;
        m_q     = 1'b0;
        m_qv    = 1'b0;
    endtask

    function automatic int pick_after(input int from, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] r, input logic [3:0] dv);
        int         nxt;
        logic [3:0] others;
        if (m_owner >= 0) begin
            m_q  = dv[m_owner];
            m_qv = 1'b1;
        end else begin
            m_qv = 1'b0;
        end
        if (m_owner < 0) begin
            nxt = pick_after(m_last, r);
        end else if (r[m_owner]) begin
            nxt = m_owner;
`ifdef HOLD_LIMIT_EN
            if (m_hold == MAX_HOLD - 1) begin
                others = r;
                others[m_owner] = 1'b0;
                if (others != 4'b0) nxt = pick_after(m_owner, others);
                else m_hold = 0;
            end else begin
                m_hold++;
            end
`else
            others = 4'b0;
`endif
        end else begin
            nxt = pick_after(m_owner, r);
        end
        if (nxt != m_owner) begin
            m_hold = 0;
            if (nxt >= 0) begin
                m_last = nxt;
                m_sel  = nxt;
            end
        end
        m_owner = nxt;
    endtask

    task automatic tick();
        model_edge(bus.req, {bus.d4, bus.d3, bus.d2, bus.d1});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0 : 4'(1 << m_owner);
        check({tag, ".grant"}, 32'(bus.grant), 32'(eg));
        check({tag, ".sel"}, 32'({bus.I1, bus.I0}), 32'(m_sel));
        check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(m_qv));
        check({tag, ".Q"}, 32'(bus.Q), 32'(m_q));
        check({tag, ".busy"}, 32'(bus.busy), 32'(m_owner >= 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] d;     // {d4,d3,d2,d1}
        logic [3:0] grant;
        logic [1:0] sel;
        logic       qv;
        logic       q;
    } vec_t;

    vec_t tbl[11];

    initial begin
        rst = 1'b1;
        bus.req = 4'b0;
        {bus.d4, bus.d3, bus.d2, bus.d1} = 4'b0;
        model_reset();

        // Reset while every requester is asking.
        bus.req = 4'b1111;
        {bus.d4, bus.d3, bus.d2, bus.d1} = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst.grant", 32'(bus.grant), 32'h0);
        check("rst.sel", 32'({bus.I1, bus.I0}), 32'h0);
        check("rst.Q", 32'(bus.Q), 32'h0);
        check("rst.q_valid", 32'(bus.q_valid), 32'h0);
        check("rst.busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        model_reset();
        tick();
        check("rel.grant", 32'(bus.grant), 32'h1);
        check("rel.q_valid0", 32'(bus.q_valid), 32'h0);
        tick();
        check("rel.q_valid1", 32'(bus.q_valid), 32'h1);
        check("rel.Q", 32'(bus.Q), 32'h1);

        // Vector table: rotation with one-cycle holders, release to idle, single requester.
        tbl[0]  = '{4'b1111, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1110, 4'b0001, 4'b0010, 2'd1, 1'b1, 1'b1};
        tbl[2]  = '{4'b1101, 4'b0010, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[3]  = '{4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[4]  = '{4'b0111, 4'b1000, 4'b0001, 2'd0, 1'b1, 1'b1};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[6]  = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
        tbl[8]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
        tbl[9]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bus.req = tbl[i].req;
            {bus.d4, bus.d3, bus.d2, bus.d1} = tbl[i].d;
            tick();
            check($sformatf("tbl%0d.grant", i), 32'(bus.grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d.sel", i), 32'({bus.I1, bus.I0}), 32'(tbl[i].sel));
            check($sformatf("tbl%0d.q_valid", i), 32'(bus.q_valid), 32'(tbl[i].qv));
            check($sformatf("tbl%0d.Q", i), 32'(bus.Q), 32'(tbl[i].q));
            check($sformatf("tbl%0d.busy", i), 32'(bus.busy), 32'(tbl[i].grant != 4'b0));
        end

        // Single requester straight out of reset (last pointer = 3), then release.
        do_reset();
        bus.req = 4'b0100;
        {bus.d4, bus.d3, bus.d2, bus.d1} = 4'b0100;
        tick();
        check("single.grant", 32'(bus.grant), 32'h4);
        check("single.sel", 32'({bus.I1, bus.I0}), 32'h2);
        tick();
        check("single.Q", 32'(bus.Q), 32'h1);
        check("single.q_valid", 32'(bus.q_valid), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("empty.grant", 32'(bus.grant), 32'h0);
        check("empty.busy", 32'(bus.busy), 32'h0);
        tick();
        check("empty.q_valid", 32'(bus.q_valid), 32'h0);
        check("empty.Q_hold", 32'(bus.Q), 32'h1);

        // Asynchronous reset between edges while requester 2 holds the grant.
        do_reset();
        bus.req = 4'b0100;
        {bus.d4, bus.d3, bus.d2, bus.d1} = 4'b0100;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst.grant", 32'(bus.grant), 32'h0);
        check("arst.Q", 32'(bus.Q), 32'h0);
        check("arst.q_valid", 32'(bus.q_valid), 32'h0);
        check("arst.busy", 32'(bus.busy), 32'h0);
        check("arst.sel", 32'({bus.I1, bus.I0}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        bus.req = 4'b1111;
        tick();
        check("arst.prio0", 32'(bus.grant), 32'h1);

`ifdef HOLD_LIMIT_EN
        // Two steady requesters alternate every MAX_HOLD cycles; a lone one is never cut off.
        do_reset();
        bus.req = 4'b0011;
        for (int c = 1; c <= 3 * MAX_HOLD; c++) begin
            tick();
            check($sformatf("hold.alt%0d", c), 32'(bus.grant),
                  ((((c - 1) / MAX_HOLD) % 2) == 1) ? 32'h2 : 32'h1);
        end
        bus.req = 4'b0001;
        for (int c = 0; c < 24; c++) begin
            tick();
            check($sformatf("hold.solo%0d", c), 32'(bus.grant), 32'h1);
        end
`else
        // Without a hold limit the holder keeps the grant while it asks.
        do_reset();
        bus.req = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("lock%0d", c), 32'(bus.grant), 32'h1);
        end
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom);
            else if ($urandom_range(0, 19) == 0) bus.req = 4'b0;
            {bus.d4, bus.d3, bus.d2, bus.d1} = 4'($urandom);
            tick();
            compare_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-1 multiplexer between four requesters.
- It drives the mux select lines I0/I1 from a registered grant, then registers the selected data onto Q with a valid flag.
- It sits in front of the existing 4:1 mux-with-buffer datapath and turns it from a manually selected mux into a clocked, fairly shared resource.

Parameters:
- DW, 1, data width of d1..d4 and Q.
- MAX_HOLD, 8, maximum consecutive grant cycles per requester when HOLD_LIMIT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[0] is requester d1, req[3] is requester d4.
- d1  input  DW  data from requester 0.
- d2  input  DW  data from requester 1.
- d3  input  DW  data from requester 2.
- d4  input  DW  data from requester 3.
- grant  output  4  registered one-hot grant, or 0 when idle.
- I0  output  1  mux select LSB (sel = {I1,I0}; 0 selects d1 ... 3 selects d4).
- I1  output  1  mux select MSB.
- Q  output  DW  registered selected data.
- q_valid  output  1  Q holds data from a granted requester.
- busy  output  1  grant is non-zero.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: grant=0, I0=0, I1=0, Q=0, q_valid=0, busy=0, last-grant pointer=3 (so requester 0 has first priority), hold counter=0.
- States:
  - IDLE: grant=0.
  - GRANT(k): grant[k]=1, {I1,I0}=k.
  - State is held as a registered grant plus a 2-bit last pointer.
- IDLE transition: if req≠0 at edge n, grant goes to the first set bit searching from last+1 upward mod 4. grant is visible in cycle n+1.
- GRANT(k), req[k]=1: stay in GRANT(k), subject to the hold limit.
- GRANT(k), req[k]=0, other requests pending: move directly to the next requester after k in rotation at the same edge; no idle bubble.
- GRANT(k), req all 0: go to IDLE.
- last pointer: updated to k whenever GRANT(k) is entered.
- Select timing: I0/I1 are combinational decodes of the registered grant. They change only at clock edges and are glitch-free with respect to req.
- I0/I1 in IDLE: hold their previous value (the mux output is ignored, q_valid=0).
- Data path: Q <= selected d at each edge where busy=1, and q_valid <= busy. Latency is req→grant 1 cycle and grant→Q 1 cycle.
- Q in idle: when busy=0, Q holds its last value and q_valid=0.
- Simultaneous events: when req[k] drops in the same cycle another bit rises, the new bit participates in that cycle's rotation.
- Stale requests: requests that are released before being granted are lost; the arbiter stores none.
- Reset mid-grant: all outputs return to reset values immediately and asynchronously. No partial Q is flagged valid.

Optional Feature:
- Macro: HOLD_LIMIT_EN.
- Defined:
  - An 8-bit hold counter increments each cycle in GRANT(k) and clears on every grant change or on entering IDLE.
  - When the count reaches MAX_HOLD-1 and any other req bit is set, the next edge forces rotation to the next requester even if req[k]=1.
  - If no other request is pending, the counter clears and GRANT(k) continues.
- Undefined: no counter is built. A requester keeps the grant for as long as it holds req (lock-until-release).

Decomposition:
- Shared package mux_arb_pkg holds:
  - the constants N_REQ=4 and SEL_W=2;
  - the function that maps a one-hot grant to a 2-bit select;
  - the round-robin next-index function.
- One sub-module is natural: mux4_datapath, the combinational 4:1 select of d1..d4 by {I1,I0}. It is instantiated inside, and its output feeds the Q register.

Test Plan:
- Reset: rst=1 with req=4'b1111 → grant=0, I1I0=00, Q=0, q_valid=0. rst released → grant=0001 next edge, q_valid=1 one edge later with Q=d1.
- All requesting, then releases: req=1111, each holder drops req after 1 cycle → grant sequence 0001,0010,0100,1000,0001; I1I0=00,01,10,11,00.
- Single requester: req=0100 from IDLE with last=3 → grant=0100, I1I0=10. Set d3=1, d1=d2=d4=0 → Q=1 two edges after req.
- Release to empty: req falls 0100→0000 → grant=0 and busy=0 next edge; q_valid=0 the edge after; Q holds its value.
- HOLD_LIMIT_EN with MAX_HOLD=8: req=0011 held constantly → grant alternates 0001/0010 every 8 cycles. Then req=0001 only → grant 0001 held for 20+ cycles without drop.
- Async reset mid-grant: assert rst between edges during GRANT(2) → grant, Q and q_valid go to 0 before the next edge. After release, requester 0 has priority again.
